rv0_ifu: RTL and testbench

RV0_IFU -- requirements
Module: rv0_ifu

---
 rtl/rv0_core_pkg.sv | 10 +
 rtl/rv_sbuf_if.sv | 13 +
 rtl/rv0_ifu_fifo.sv | 43 ++++
 rtl/rv0_ifu.sv | 68 ++++++
 tb/tb_rv0_ifu.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/rv0_core_pkg.sv
// rv0_core_pkg: shared core widths, reset vector and the fetch entry layout.
package rv0_core_pkg;
   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
   typedef struct packed {
      logic [ILEN-1:0] insn;
      logic [XLEN-1:0] addr;
   } fetch_entry_t;
endpackage

// File: rtl/rv_sbuf_if.sv
// rv_sbuf_if: valid/ack stream of fetched instructions with their addresses.
interface rv_sbuf_if
   import rv0_core_pkg::*;
#(
   parameter int XLEN = rv0_core_pkg::XLEN
);
   logic [ILEN-1:0] insn;
   logic [XLEN-1:0] addr;
   logic            rdy;
   logic            ack;
   modport source (output insn, addr, rdy, input ack);
   modport sink (input insn, addr, rdy, output ack);
endinterface

// File: rtl/rv0_ifu_fifo.sv
// rv0_ifu_fifo: small circular buffer with push, pop, clear and an occupancy count.
module rv0_ifu_fifo
   import rv0_core_pkg::*;
#(
   parameter int W     = $bits(fetch_entry_t),
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  data,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd, wr;
   logic          do_pop;
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
   endfunction
   assign do_pop = pop && count != '0;
   assign head = mem[rd];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else if (clear) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else begin
         if (push) wr <= inc(wr);
         if (do_pop) rd <= inc(rd);
         count <= count + CW'(push) - CW'(do_pop);
      end
   always_ff @(posedge clk)
      if (push && !clear) mem[wr] <= data;
endmodule

// File: rtl/rv0_ifu.sv
// rv0_ifu: in-order instruction fetch with bounded outstanding requests and flush redirect.
module rv0_ifu
   import rv0_core_pkg::*;
#(
   parameter int              XLEN       = rv0_core_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(rv0_core_pkg::RESET_ADDR),
   parameter int              FIFO_DEPTH = 2
)(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            ifu_flush_i,
   input  logic [XLEN-1:0] ifu_flush_addr_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_rdata_i,
   rv_sbuf_if.source       ifu_sbuf_if
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);
   logic [XLEN-1:0]      pc_q, rsp_pc_q, tgt;
   logic [CW-1:0]        outstanding_q, discard_q, fifo_count, left_q;
   logic [CW:0]          inflight;
   logic                 grant, keep, pop;
   logic [ILEN+XLEN-1:0] head;
   assign tgt = ifu_flush_addr_i & ALIGN;
   assign inflight = {1'b0, outstanding_q} + {1'b0, fifo_count};
   assign imem_req_o = !rst_i && !ifu_flush_i && inflight < (CW+1)'(FIFO_DEPTH);
   assign imem_addr_o = pc_q;
   assign grant = imem_req_o && imem_gnt_i;
   assign keep = imem_rvalid_i && discard_q == '0 && !ifu_flush_i;
   assign pop = ifu_sbuf_if.rdy && ifu_sbuf_if.ack;
   assign ifu_sbuf_if.rdy = fifo_count != '0;
   assign {ifu_sbuf_if.insn, ifu_sbuf_if.addr} = head;
   // every request still in flight at a flush belongs to the old stream
   assign left_q = outstanding_q - CW'(imem_rvalid_i);
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         pc_q          <= RESET_ADDR & ALIGN;
         rsp_pc_q      <= RESET_ADDR & ALIGN;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else if (ifu_flush_i) begin
         pc_q          <= tgt;
         rsp_pc_q      <= tgt;
         outstanding_q <= left_q;
         discard_q     <= left_q;
      end else begin
         if (grant) pc_q <= pc_q + XLEN'(4);
         if (keep) rsp_pc_q <= rsp_pc_q + XLEN'(4);
         if (imem_rvalid_i && discard_q != '0) discard_q <= discard_q - 1'b1;
         outstanding_q <= outstanding_q + CW'(grant) - CW'(imem_rvalid_i);
      end
   rv0_ifu_fifo #(
      .W     (ILEN + XLEN),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .clear (ifu_flush_i),
      .push  (keep),
      .pop   (pop),
      .data  ({imem_rdata_i, rsp_pc_q}),
      .head  (head),
      .count (fifo_count)
   );
endmodule

// File: tb/tb_rv0_ifu.sv
// tb_rv0_ifu: randomized fetch traffic against a request/epoch model of the fetch unit.
module tb_rv0_ifu;
   import rv0_core_pkg::*;
   localparam int DEPTH = 2;
   localparam logic [31:0] RST = 32'h100;
   logic        clk_i = 0, rst_i = 1, ifu_flush_i = 0, imem_gnt_i = 0, imem_rvalid_i = 0;
   logic [31:0] ifu_flush_addr_i = 0, imem_rdata_i = 0, imem_addr_o;
   logic        imem_req_o;
   rv_sbuf_if #(.XLEN(32)) sbuf ();
   rv0_ifu #(.XLEN(32), .RESET_ADDR(RST), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .ifu_flush_i(ifu_flush_i), .ifu_flush_addr_i(ifu_flush_addr_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .ifu_sbuf_if(sbuf.source)
   );
   always #5 clk_i = ~clk_i;
   int n_checks = 0, n_fail = 0;
   int gnt_p = 100, rv_p = 100, ack_p = 100, epoch = 0;
   logic flush_n = 0;
   logic [31:0] flush_tgt = 0, m_pc = RST;
   logic [31:0] pend_addr[$], issued[$], seen_addr[$], seen_insn[$];
   int pend_ep[$];
   fetch_entry_t fifoq[$];
   function automatic logic [31:0] hash(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction
   function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
      return i < q.size() ? q[i] : 32'hDEAD_BEEF;
   endfunction
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic clear_logs();
      issued.delete();
      seen_addr.delete();
      seen_insn.delete();
   endtask
   task automatic cycle();
      logic rq, rv, gn, ak, fl;
      logic [31:0] fa, ra;
      int e;
      @(negedge clk_i);
      fl = flush_n;
      fa = flush_tgt;
      flush_n = 0;
      gn = $urandom_range(99) < gnt_p;
      ak = $urandom_range(99) < ack_p;
      rv = pend_addr.size() > 0 && $urandom_range(99) < rv_p;
      ifu_flush_i = fl;
      ifu_flush_addr_i = fa;
      imem_gnt_i = gn;
      sbuf.ack = ak;
      imem_rvalid_i = rv;
      imem_rdata_i = rv ? hash(pend_addr[0]) : $urandom();
      #1;
      assert (!(rv && pend_addr.size() == 0)) else $error("rvalid with nothing outstanding");
      rq = !fl && (pend_addr.size() + fifoq.size() < DEPTH);
      check("req", imem_req_o, rq);
      if (rq) check("req_addr", imem_addr_o, m_pc);
      check("rdy", sbuf.rdy, fifoq.size() > 0);
      if (fifoq.size() > 0) begin
         check("insn", sbuf.insn, fifoq[0].insn);
         check("sbuf_addr", sbuf.addr, fifoq[0].addr);
      end
      if (imem_req_o && gn) issued.push_back(imem_addr_o);
      if (sbuf.rdy && ak && !fl) begin
         seen_addr.push_back(sbuf.addr);
         seen_insn.push_back(sbuf.insn);
      end
      ra = 0;
      e = -1;
      if (rv) begin
         ra = pend_addr.pop_front();
         e = pend_ep.pop_front();
      end
      if (fl) begin
         fifoq.delete();
         epoch++;
         m_pc = {fa[31:2], 2'b00};
      end else begin
         if (fifoq.size() > 0 && ak) void'(fifoq.pop_front());
         if (rv && e == epoch) fifoq.push_back('{insn: hash(ra), addr: ra});
         if (rq && gn) begin
            pend_addr.push_back(m_pc);
            pend_ep.push_back(epoch);
            m_pc += 4;
         end
      end
   endtask
   task automatic run(input int n);
      repeat (n) cycle();
   endtask
   task automatic reset_dut();
      @(negedge clk_i);
      #2 rst_i = 1;
      imem_gnt_i = 0;
      imem_rvalid_i = 0;
      ifu_flush_i = 0;
      #1;
      check("rst_req", imem_req_o, 0);
      check("rst_rdy", sbuf.rdy, 0);
      pend_addr.delete();
      pend_ep.delete();
      fifoq.delete();
      m_pc = RST;
      flush_n = 0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 0;
   endtask
   task automatic set_p(input int g, input int r, input int a);
      gnt_p = g;
      rv_p = r;
      ack_p = a;
   endtask
   task automatic flush_to(input logic [31:0] t);
      flush_n = 1;
      flush_tgt = t;
      cycle();
   endtask
   initial begin
      sbuf.ack = 0;
      #3;
      check("init_req", imem_req_o, 0);
      check("init_rdy", sbuf.rdy, 0);
      // streaming from the reset vector
      reset_dut();
      clear_logs();
      set_p(100, 100, 100);
      run(10);
      check("s_iss0", qget(issued, 0), 32'h100);
      check("s_iss1", qget(issued, 1), 32'h104);
      check("s_iss2", qget(issued, 2), 32'h108);
      check("s_seen0", qget(seen_addr, 0), 32'h100);
      check("s_seen1", qget(seen_addr, 1), 32'h104);
      check("s_insn0", qget(seen_insn, 0), hash(32'h100));
      // consumer stall fills the buffer
      reset_dut();
      clear_logs();
      set_p(100, 100, 0);
      run(10);
      check("stall_reqs", issued.size(), 2);
      check("stall_rdy", sbuf.rdy, 1);
      check("stall_req", imem_req_o, 0);
      ack_p = 100;
      run(6);
      check("resume_addr", qget(issued, 2), 32'h108);
      // flush with two requests outstanding
      reset_dut();
      set_p(100, 0, 100);
      run(3);
      check("two_out", pend_addr.size(), 2);
      clear_logs();
      flush_to(32'h2003);
      rv_p = 100;
      run(8);
      check("fl_iss0", qget(issued, 0), 32'h2000);
      check("fl_seen0", qget(seen_addr, 0), 32'h2000);
      check("fl_insn0", qget(seen_insn, 0), hash(32'h2000));
      // flush coinciding with the only response
      reset_dut();
      set_p(100, 0, 100);
      run(1);
      clear_logs();
      set_p(0, 100, 100);
      flush_to(32'h500);
      set_p(100, 100, 100);
      run(6);
      check("fr_iss0", qget(issued, 0), 32'h500);
      check("fr_seen0", qget(seen_addr, 0), 32'h500);
      // address wrap
      reset_dut();
      clear_logs();
      flush_to(32'hFFFF_FFFC);
      run(4);
      check("wrap0", qget(issued, 0), 32'hFFFF_FFFC);
      check("wrap1", qget(issued, 1), 32'h0);
      // back-to-back flushes, last wins
      clear_logs();
      flush_to(32'h3000);
      flush_to(32'h4000);
      run(6);
      check("b2b_iss0", qget(issued, 0), 32'h4000);
      check("b2b_seen0", qget(seen_addr, 0), 32'h4000);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (i % 100 == 0) set_p($urandom_range(100, 20), $urandom_range(100, 20), $urandom_range(100, 10));
         if ($urandom_range(24) == 0) begin
            flush_n = 1;
            flush_tgt = $urandom_range(3) == 0 ? 32'hFFFF_FFF0 | $urandom_range(15) : $urandom();
         end
         if ($urandom_range(599) == 0) reset_dut();
         cycle();
      end
      // asynchronous reset with a full buffer
      set_p(100, 100, 0);
      run(8);
      check("full_rdy", sbuf.rdy, 1);
      reset_dut();
      clear_logs();
      set_p(100, 100, 100);
      run(4);
      check("restart0", qget(issued, 0), RST);
      check("restart_seen0", qget(seen_addr, 0), RST);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
